inv_mixcol_seq: RTL and testbench

Multi-cycle InvMixColumns sequencer for the AES decrypt path. Accepts a 128-bit state over a valid/ready handshake and runs one 32-bit column per cycle through a single shared GF(2^8) column unit. The unit multiplies by {0e},{0b},{0d},{09}. The sequencer then presents the transformed state with backpressure. It sits between InvShiftRows/InvSubBytes and AddRoundKey, trading 4 cycles of latency for one column unit instead of four.

---
 rtl/inv_mixcol_seq_if.sv | 25 ++
 rtl/inv_mixcol_seq.sv | 161 ++++++++++++++++
 tb/tb_inv_mixcol_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/inv_mixcol_seq_if.sv
// Handshake bundle for the InvMixColumns sequencer.
// Input side: in_valid/in_ready/in_state/mode. Output side: out_valid/out_ready/out_state.
// busy is a status flag that is high while columns are being processed.
// master = the surrounding datapath (drives stimulus, accepts results);
// slave  = the sequencer itself.
interface inv_mixcol_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, mode, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, mode, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/inv_mixcol_seq.sv
// Purpose: InvMixColumns (optionally MixColumns) on a 128-bit AES state, one column per cycle.
// Latency: 4 cycles from input acceptance to out_valid; one state per 6 cycles at full rate.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      inv_mixcol_seq_if.slave: in_valid/in_ready/in_state/mode, out_valid/out_ready/out_state, busy
// Byte 0 sits at [127:120]; column c occupies [127-32c -: 32].
// Build option: define INVMIXCOL_FWD_EN to let mode=1 (sampled at acceptance) select
// forward MixColumns through the same column unit. Without it mode is ignored.
module inv_mixcol_seq #(
  parameter int COLS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  inv_mixcol_seq_if.slave bus
);

  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [127:0]    st_q, st_d;
  logic [CW-1:0]   col_q, col_d;
  logic            md_q;
  logic [31:0]     col_in;
  logic [31:0]     col_out;

  // GF(2^8) multiply by {02}, reduction polynomial {11b}.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse column: rows {0e 0b 0d 09} rotated right by one per output byte.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2[i]  = xt(a[i]);
      x4[i]  = xt(x2[i]);
      x8[i]  = xt(x4[i]);
      m09[i] = a[i] ^ x8[i];
      m0b[i] = a[i] ^ x2[i] ^ x8[i];
      m0d[i] = a[i] ^ x4[i] ^ x8[i];
      m0e[i] = x2[i] ^ x4[i] ^ x8[i];
    end
    return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
            m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
            m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
            m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
  endfunction

`ifdef INVMIXCOL_FWD_EN
  // Forward column: rows {02 03 01 01} rotated right by one per output byte.
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a   [4];
    logic [7:0] x2  [4];
    logic [7:0] m03 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2[i]  = xt(a[i]);
      m03[i] = a[i] ^ x2[i];
    end
    return {x2[0]  ^ m03[1] ^ a[2]   ^ a[3],
            a[0]   ^ x2[1]  ^ m03[2] ^ a[3],
            a[0]   ^ a[1]   ^ x2[2]  ^ m03[3],
            m03[0] ^ a[1]   ^ a[2]   ^ x2[3]};
  endfunction

  logic md_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) md_q <= 1'b0;
    else          md_q <= md_d;
  end

  always_comb begin
    md_d = md_q;
    if (state_q == IDLE && bus.in_valid) md_d = bus.mode;
  end

  assign col_out = md_q ? fwd_col(col_in) : inv_col(col_in);
`else
  // mode has no effect in this build; only the inverse unit exists.
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign md_q        = 1'b0;
  assign col_out     = inv_col(col_in);
`endif

  // Column currently addressed by col_q feeds the shared unit.
  always_comb begin
    col_in = 32'h0;
    for (int c = 0; c < COLS; c++) begin
      if (col_q == CW'(c)) col_in = st_q[127-32*c -: 32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      st_q    <= 128'h0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          st_d    = bus.in_state;
          col_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Write the transformed column back in place.
        for (int c = 0; c < COLS; c++) begin
          if (col_q == CW'(c)) st_d[127-32*c -: 32] = col_out;
        end
        if (col_q == CW'(COLS-1)) begin
          col_d   = '0;
          state_d = DONE;
        end else begin
          col_d   = col_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs come from registered state only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_state = st_q;

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Bench for inv_mixcol_seq: directed vectors, scoreboard queue filled at acceptance,
// independent monitor pops and compares on every output handshake.
module tb_inv_mixcol_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  inv_mixcol_seq_if bus ();

  inv_mixcol_seq #(.COLS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [127:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] A_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] A_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] F_IN  = 128'hdb135345_f20a225c_d4d4d4d5_2d262631;
  localparam logic [127:0] F_FWD = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] F_INV = 128'h32a41d55_aec36982_ddd9dfda_eb86d8a9;
  // Columns of equal bytes are fixed points of both transforms.
  localparam logic [127:0] C_IN  = 128'h01010101_c6c6c6c6_d4d4d4d4_26262626;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin : monitor
    logic [127:0] e;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h expected no output", bus.out_state);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", bus.out_state, e);
      end
    end
  end

  // Called at posedge+1. Returns at acceptance edge +1 with in_valid dropped.
  task automatic send(input logic [127:0] s, input logic m, input logic [127:0] want,
                      output int acc);
    int n;
    bus.in_state = s;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    exp_q.push_back(want);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n, a0, a1, a2, busy_cnt;
    logic [127:0] snap;
    logic ok;

    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    #2;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy",      bus.busy,      0);
    check("rst_out_state", bus.out_state, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single inverse op
    bus.out_ready = 1'b1;
    send(A_IN, 1'b0, A_OUT, a0);
    wait_valid(n);
    check("latency_single", n, 4);
    @(posedge clk); #1;
    check("in_ready_after_single", bus.in_ready, 1);

    // Backpressure: hold result for 10 cycles
    bus.out_ready = 1'b0;
    send(A_IN, 1'b0, A_OUT, a0);
    wait_valid(n);
    check("latency_bp", n, 4);
    snap = bus.out_state;
    check("bp_value", snap, A_OUT);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_state !== snap || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) ok = 1'b0;
    end
    check("bp_hold_stable", ok, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_next", bus.in_ready, 1);
    check("bp_out_valid_drop", bus.out_valid, 0);

    // Ignored inputs during RUN; busy must be high exactly 4 sampled cycles
    send(A_IN, 1'b0, A_OUT, a0);
    busy_cnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      bus.mode     = 1'b1;
      @(posedge clk); #1;
      busy_cnt += bus.busy ? 1 : 0;
    end
    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      busy_cnt += bus.busy ? 1 : 0;
    end
    check("busy_cycles", busy_cnt, 4);
    check("no_second_accept", bus.busy, 0);

    // Mid-op reset two cycles after acceptance
    send(A_IN, 1'b0, A_OUT, a0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_state", bus.out_state, 0);
    check("mid_rst_in_ready",  bus.in_ready,  1);
    check("mid_rst_busy",      bus.busy,      0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send(C_IN, 1'b0, C_IN, a0);
    wait_valid(n);
    check("latency_after_rst", n, 4);
    @(posedge clk); #1;

    // Forward mode request
`ifdef INVMIXCOL_FWD_EN
    send(F_IN, 1'b1, F_FWD, a0);
`else
    send(F_IN, 1'b1, F_INV, a0);
`endif
    wait_valid(n);
    check("latency_mode1", n, 4);
    @(posedge clk); #1;

    // Back-to-back with in_valid and out_ready held high
    send(A_IN, 1'b0, A_OUT, a0);
    send(F_IN, 1'b0, F_INV, a1);
    send(C_IN, 1'b0, C_IN,  a2);
    check("b2b_gap_1", a1 - a0, 6);
    check("b2b_gap_2", a2 - a1, 6);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
